// File: rtl/eth_tx_arbiter.sv
// Round-robin packet arbiter in front of a shared eth_framer.
// Holds header fields per frame, gates framer output, inserts an IFG.
module eth_tx_arbiter #(
  parameter int NUM_SRC    = 2,
  parameter int IFG_OCTETS = 12
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic [NUM_SRC-1:0]      src_axis_tvalid,
  output logic [NUM_SRC-1:0]      src_axis_tready,
  input  logic [NUM_SRC-1:0]      src_axis_tlast,
  input  logic [NUM_SRC*8-1:0]    src_axis_tdata,
  input  logic [NUM_SRC*48-1:0]   src_dst_mac,
  input  logic [NUM_SRC*16-1:0]   src_ethertype,
  output logic [47:0]             dst_mac,
  output logic [15:0]             ethertype,
  input  logic                    payload_axis_tready,
  output logic                    payload_axis_tvalid,
  output logic                    payload_axis_tlast,
  output logic [7:0]              payload_axis_tdata,
  output logic                    frm_axis_tready,
  input  logic                    frm_axis_tvalid,
  input  logic                    frm_axis_tlast,
  input  logic [7:0]              frm_axis_tdata,
  input  logic                    out_axis_tready,
  output logic                    out_axis_tvalid,
  output logic                    out_axis_tlast,
  output logic [7:0]              out_axis_tdata,
  output logic [$clog2(NUM_SRC)-1:0] grant,
  output logic                    busy
);

  localparam int GW = $clog2(NUM_SRC);
  localparam int CW = (IFG_OCTETS > 1) ? $clog2(IFG_OCTETS + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    FRAME,
    DRAIN,
    GAP
  } state_e;

  state_e        state_q;
  logic [GW-1:0] ptr_q;
  logic [GW-1:0] grant_q;
  logic [47:0]   mac_q;
  logic [15:0]   et_q;
  logic          pl_done_q;
  logic [CW-1:0] cnt_q;

  logic [GW-1:0] pick_d;
  logic          found;
  logic          in_frame;
  logic          active;
  logic          pl_last_hs;
  logic          out_last_hs;
  logic          frame_end;

  // First requester strictly after the last winner, wrapping.
  always_comb begin
    pick_d = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (!found && src_axis_tvalid[(int'(ptr_q) + k) % NUM_SRC]) begin
        found  = 1'b1;
        pick_d = GW'((int'(ptr_q) + k) % NUM_SRC);
      end
    end
  end

  assign in_frame = (state_q == FRAME);
  assign active   = (state_q == FRAME) || (state_q == DRAIN);

  assign payload_axis_tvalid = in_frame & src_axis_tvalid[grant_q];
  assign payload_axis_tlast  = src_axis_tlast[grant_q];
  assign payload_axis_tdata  = src_axis_tdata[{grant_q, 3'b000} +: 8];

  always_comb begin
    src_axis_tready = '0;
    if (in_frame)
      src_axis_tready[grant_q] = payload_axis_tready;
  end

  assign out_axis_tvalid = active & frm_axis_tvalid;
  assign out_axis_tlast  = frm_axis_tlast;
  assign out_axis_tdata  = frm_axis_tdata;
  assign frm_axis_tready = active & out_axis_tready;

  assign pl_last_hs  = payload_axis_tvalid & payload_axis_tready
                     & payload_axis_tlast;
  assign out_last_hs = out_axis_tvalid & out_axis_tready & frm_axis_tlast;
  // An output tlast only closes the frame once the payload has ended.
  assign frame_end   = out_last_hs & (pl_done_q | pl_last_hs);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      ptr_q     <= GW'(NUM_SRC - 1);
      grant_q   <= '0;
      mac_q     <= '0;
      et_q      <= '0;
      pl_done_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (found) begin
            grant_q <= pick_d;
            ptr_q   <= pick_d;
            mac_q   <= src_dst_mac[int'(pick_d)*48 +: 48];
            et_q    <= src_ethertype[int'(pick_d)*16 +: 16];
            state_q <= FRAME;
          end
        end
        FRAME, DRAIN: begin
          if (frame_end) begin
            pl_done_q <= 1'b0;
            cnt_q     <= CW'(IFG_OCTETS);
            state_q   <= (IFG_OCTETS == 0) ? IDLE : GAP;
          end else if (pl_last_hs) begin
            pl_done_q <= 1'b1;
            state_q   <= DRAIN;
          end
        end
        GAP: begin
          if (cnt_q <= CW'(1)) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant     = grant_q;
  assign dst_mac   = mac_q;
  assign ethertype = et_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter with a small framer and source model.
// A second instance runs with IFG_OCTETS=0.
module tb_eth_tx_arbiter;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Source model
  int          req[2];
  int          done[2];
  int          idx[2];
  int          len[2];
  logic [7:0]  base[2];
  logic [47:0] mac[2];
  logic [15:0] et[2];

  logic [1:0]  s_tvalid, s_tready, s_tlast;
  logic [15:0] s_tdata;
  logic [95:0] s_mac;
  logic [31:0] s_et;

  always_comb begin
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    s_mac    = '0;
    s_et     = '0;
    for (int i = 0; i < 2; i++) begin
      s_tvalid[i]       = done[i] < req[i];
      s_tlast[i]        = idx[i] == len[i] - 1;
      s_tdata[i*8 +: 8] = base[i] + 8'(idx[i]);
      s_mac[i*48 +: 48] = mac[i];
      s_et[i*16 +: 16]  = et[i];
    end
  end

  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < 2; i++) begin
        idx[i]  <= 0;
        done[i] <= req[i];
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s_tvalid[i] && s_tready[i]) begin
          if (s_tlast[i]) begin
            idx[i]  <= 0;
            done[i] <= done[i] + 1;
          end else begin
            idx[i] <= idx[i] + 1;
          end
        end
      end
    end
  end

  // DUT-facing framer and output signals
  logic [47:0] dmac;
  logic [15:0] etype;
  logic        p_tready, p_tvalid, p_tlast;
  logic [7:0]  p_tdata;
  logic        frm_tready, frm_tvalid, frm_tlast;
  logic [7:0]  frm_tdata;
  logic        o_tready, o_tvalid, o_tlast;
  logic [7:0]  o_tdata;
  logic        gnt;
  logic        busy;

  // Framer model: queues header on first payload sight, then payload
  logic [8:0]  fb[256];
  logic [7:0]  hd, tl;
  logic        hdr_done;
  logic        force_v;
  logic [47:0] smac = 48'h020000000001;

  assign frm_tvalid = force_v | (hd != tl);
  assign frm_tdata  = fb[hd][7:0];
  assign frm_tlast  = (hd != tl) & fb[hd][8];
  assign p_tready   = hdr_done;

  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      hd       <= '0;
      tl       <= '0;
      hdr_done <= 1'b0;
    end else begin
      if (p_tvalid && !hdr_done) begin
        for (int k = 0; k < 7; k++)
          fb[tl + 8'(k)] <= {1'b0, 8'h55};
        fb[tl + 8'd7] <= {1'b0, 8'hD5};
        for (int k = 0; k < 6; k++) begin
          fb[tl + 8'(8 + k)]  <= {1'b0, dmac[47 - 8*k -: 8]};
          fb[tl + 8'(14 + k)] <= {1'b0, smac[47 - 8*k -: 8]};
        end
        fb[tl + 8'd20] <= {1'b0, etype[15:8]};
        fb[tl + 8'd21] <= {1'b0, etype[7:0]};
        tl       <= tl + 8'd22;
        hdr_done <= 1'b1;
      end
      if (p_tvalid && p_tready) begin
        fb[tl] <= {p_tlast, p_tdata};
        tl     <= tl + 8'd1;
      end
      if (frm_tvalid && frm_tready && hd != tl) begin
        hd <= hd + 8'd1;
        if (frm_tlast) hdr_done <= 1'b0;
      end
    end
  end

  logic bp_mode = 1'b0;
  logic tog = 1'b0;
  always @(negedge clk) tog <= ~tog;
  assign o_tready = bp_mode ? tog : 1'b1;

  eth_tx_arbiter #(.NUM_SRC(2), .IFG_OCTETS(12)) u0 (
    .clk                 (clk),
    .aresetn             (aresetn),
    .src_axis_tvalid     (s_tvalid),
    .src_axis_tready     (s_tready),
    .src_axis_tlast      (s_tlast),
    .src_axis_tdata      (s_tdata),
    .src_dst_mac         (s_mac),
    .src_ethertype       (s_et),
    .dst_mac             (dmac),
    .ethertype           (etype),
    .payload_axis_tready (p_tready),
    .payload_axis_tvalid (p_tvalid),
    .payload_axis_tlast  (p_tlast),
    .payload_axis_tdata  (p_tdata),
    .frm_axis_tready     (frm_tready),
    .frm_axis_tvalid     (frm_tvalid),
    .frm_axis_tlast      (frm_tlast),
    .frm_axis_tdata      (frm_tdata),
    .out_axis_tready     (o_tready),
    .out_axis_tvalid     (o_tvalid),
    .out_axis_tlast      (o_tlast),
    .out_axis_tdata      (o_tdata),
    .grant               (gnt),
    .busy                (busy)
  );

  // Zero-gap instance: src1 sends 1-byte frames, framer always ready
  logic        u1_en = 1'b0;
  logic [1:0]  u1_s_tready;
  logic [47:0] u1_dmac;
  logic [15:0] u1_etype;
  logic        u1_p_tvalid, u1_p_tlast;
  logic [7:0]  u1_p_tdata;
  logic        u1_frm_tready;
  logic        u1_o_tvalid, u1_o_tlast;
  logic [7:0]  u1_o_tdata;
  logic        u1_gnt;
  logic        u1_busy;

  eth_tx_arbiter #(.NUM_SRC(2), .IFG_OCTETS(0)) u1 (
    .clk                 (clk),
    .aresetn             (aresetn),
    .src_axis_tvalid     ({u1_en, 1'b0}),
    .src_axis_tready     (u1_s_tready),
    .src_axis_tlast      (2'b11),
    .src_axis_tdata      (16'h5A5A),
    .src_dst_mac         (s_mac),
    .src_ethertype       (s_et),
    .dst_mac             (u1_dmac),
    .ethertype           (u1_etype),
    .payload_axis_tready (1'b1),
    .payload_axis_tvalid (u1_p_tvalid),
    .payload_axis_tlast  (u1_p_tlast),
    .payload_axis_tdata  (u1_p_tdata),
    .frm_axis_tready     (u1_frm_tready),
    .frm_axis_tvalid     (1'b1),
    .frm_axis_tlast      (1'b1),
    .frm_axis_tdata      (8'hEE),
    .out_axis_tready     (1'b1),
    .out_axis_tvalid     (u1_o_tvalid),
    .out_axis_tlast      (u1_o_tlast),
    .out_axis_tdata      (u1_o_tdata),
    .grant               (u1_gnt),
    .busy                (u1_busy)
  );

  // Output monitor
  logic [8:0] olog[512];
  int         olen = 0;
  int         nfrm = 0;
  int         glog[32];

  always @(posedge clk) begin
    if (o_tvalid && o_tready) begin
      olog[olen] <= {o_tlast, o_tdata};
      olen       <= olen + 1;
      chk("mac_stable", 64'(dmac), 64'(mac[gnt]));
      chk("et_stable", 64'(etype), 64'(et[gnt]));
      if (o_tlast) begin
        glog[nfrm] <= int'(gnt);
        nfrm       <= nfrm + 1;
      end
    end
    for (int i = 0; i < 2; i++)
      if (s_tvalid[i] && s_tready[i])
        chk("src_granted", 64'(gnt), 64'(i));
  end

  logic [8:0] ex[64];
  int         exn;

  task automatic build_exp(input int s);
    for (int k = 0; k < 7; k++) ex[k] = {1'b0, 8'h55};
    ex[7] = {1'b0, 8'hD5};
    for (int k = 0; k < 6; k++) begin
      ex[8 + k]  = {1'b0, mac[s][47 - 8*k -: 8]};
      ex[14 + k] = {1'b0, smac[47 - 8*k -: 8]};
    end
    ex[20] = {1'b0, et[s][15:8]};
    ex[21] = {1'b0, et[s][7:0]};
    for (int k = 0; k < len[s]; k++)
      ex[22 + k] = {k == len[s] - 1, base[s] + 8'(k)};
    exn = 22 + len[s];
  endtask

  task automatic cmp_frame(input string tag, input int start);
    chk({tag, "_beats"}, 64'(olen - start), 64'(exn));
    for (int k = 0; k < exn; k++)
      chk(tag, 64'(olog[start + k]), 64'(ex[k]));
  endtask

  task automatic wait_frames(input int target, input int budget);
    int b;
    b = budget;
    while (nfrm < target && b > 0) begin
      @(negedge clk);
      b--;
    end
    chk("frames_done", 64'(nfrm), 64'(target));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_grant"}, 64'(gnt), 64'(0));
    chk({tag, "_mac"}, 64'(dmac), 64'(0));
    chk({tag, "_et"}, 64'(etype), 64'(0));
    chk({tag, "_valids"}, 64'({o_tvalid, p_tvalid, s_tready, frm_tready}),
        64'(0));
  endtask

  initial begin
    int n, ostart, f;
    force_v = 1'b0;
    req[0] = 0; req[1] = 0;
    len[0] = 2; len[1] = 2;
    base[0] = 8'h10; base[1] = 8'h20;
    mac[0] = 48'h0A0B0C0D0E0F; mac[1] = 48'h112233445566;
    et[0] = 16'h0800; et[1] = 16'h86DD;
    repeat (3) @(negedge clk);
    chk_reset_outs("rst");
    aresetn = 1'b1;
    @(negedge clk);

    // Zero IFG: one busy cycle per frame, one idle cycle between frames
    u1_en = 1'b1;
    n = 0;
    while (!u1_busy && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (u1_busy && n < 20) begin @(negedge clk); n++; end
    chk("ifg0_busy_run", 64'(n), 64'(1));
    n = 0;
    while (!u1_busy && n < 20) begin @(negedge clk); n++; end
    chk("ifg0_idle_run", 64'(n), 64'(1));
    chk("ifg0_grant", 64'(u1_gnt), 64'(1));
    u1_en = 1'b0;
    repeat (3) @(negedge clk);

    // Contention: two 2-byte frames each, grants alternate
    req[0] = 2; req[1] = 2;
    wait_frames(4, 600);
    chk("rr_g0", 64'(glog[0]), 64'(0));
    chk("rr_g1", 64'(glog[1]), 64'(1));
    chk("rr_g2", 64'(glog[2]), 64'(0));
    chk("rr_g3", 64'(glog[3]), 64'(1));
    for (int k = 0; k < 4; k++) begin
      chk("rr_pl0", 64'(olog[k*24 + 22]), 64'({1'b0, base[k % 2]}));
      chk("rr_pl1", 64'(olog[k*24 + 23]), 64'({1'b1, base[k % 2] + 8'd1}));
    end
    while (busy && n < 200) begin @(negedge clk); n++; end

    // Single source, 4-byte payload, then the 12-cycle gap
    len[0] = 4; base[0] = 8'hA1;
    ostart = olen;
    req[0] = 3;
    wait_frames(5, 300);
    n = 0;
    while (busy && n < 100) begin
      chk("gap_quiet", 64'(o_tvalid), 64'(0));
      @(negedge clk);
      n++;
    end
    chk("gap_len", 64'(n), 64'(12));
    chk("single_grant", 64'(glog[4]), 64'(0));
    build_exp(0);
    cmp_frame("single", ostart);

    // Framer presents data with no grant outstanding
    force_v = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("pregrant_gate", 64'({o_tvalid, frm_tready}), 64'(0));
    end
    force_v = 1'b0;

    // Downstream back-pressure every other cycle
    bp_mode = 1'b1;
    len[0] = 5; base[0] = 8'h30;
    ostart = olen;
    req[0] = 4;
    wait_frames(6, 400);
    build_exp(0);
    cmp_frame("bp", ostart);
    bp_mode = 1'b0;
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end

    // Reset while the 3rd payload byte is presented
    len[0] = 6; base[0] = 8'h40;
    req[0] = 5;
    n = 0;
    while (!(idx[0] == 2 && s_tvalid[0]) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_byte3", 64'(idx[0]), 64'(2));
    #1 aresetn = 1'b0;
    #1 chk_reset_outs("midrst");
    @(negedge clk);
    aresetn = 1'b1;
    f = nfrm;
    len[0] = 2; base[0] = 8'h50;
    req[0] = 6; req[1] = 3;
    wait_frames(f + 2, 400);
    chk("post_rst_g0", 64'(glog[f]), 64'(0));
    chk("post_rst_g1", 64'(glog[f + 1]), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
